// File: rtl/ls_issue_queue_if.sv
// ls_issue_queue_if: issue-side, dcache-request and result-port signals of the load/store issue queue.
interface ls_issue_queue_if;
    logic        in_valid;
    logic        in_ready;
    logic        in_store;
    logic [15:0] in_addr;
    logic [31:0] in_wdata;
    logic [5:0]  in_tag;
    logic        dc_en;
    logic        dc_wen;
    logic [15:0] dc_addr;
    logic [31:0] dc_wdata;
    logic [5:0]  dc_tag;
    logic [31:0] dc_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  out_tag;
    logic [31:0] out_data;
    logic        out_store;
    modport slave (
        input  in_valid, in_store, in_addr, in_wdata, in_tag, dc_rdata, out_ready,
        output in_ready, dc_en, dc_wen, dc_addr, dc_wdata, dc_tag, out_valid, out_tag, out_data, out_store
    );
    modport master (
        output in_valid, in_store, in_addr, in_wdata, in_tag, dc_rdata, out_ready,
        input  in_ready, dc_en, dc_wen, dc_addr, dc_wdata, dc_tag, out_valid, out_tag, out_data, out_store
    );
endinterface

// File: rtl/ls_issue_queue.sv
// ls_issue_queue: in-order load/store queue feeding the dcache, with credit-limited issue into a 2-entry result FIFO.
module ls_issue_queue #(
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    ls_issue_queue_if.slave q_if
);
    localparam int AW = $clog2(DEPTH);
    logic          r_st    [DEPTH];
    logic [15:0]   r_addr  [DEPTH];
    logic [31:0]   r_wd    [DEPTH];
    logic [5:0]    r_tag   [DEPTH];
    logic [AW-1:0] r_wp, r_rp;
    logic [AW:0]   r_count;
    logic          r_inflight, r_if_store;
    logic [5:0]    r_if_tag;
    logic          r_rq_st   [2];
    logic [5:0]    r_rq_tag  [2];
    logic [31:0]   r_rq_data [2];
    logic          r_rq_wp, r_rq_rp;
    logic [1:0]    r_rq_count;
    logic          w_push, w_issue, w_pop;
    logic [2:0]    w_credit;
    assign q_if.in_ready = r_count != (AW+1)'(DEPTH);
    assign w_push        = q_if.in_valid && q_if.in_ready;
    assign w_pop         = q_if.out_valid && q_if.out_ready;
    // Slots the dcache result could still need: buffered + in flight, less the one leaving now
    assign w_credit      = 3'(r_rq_count) + 3'(r_inflight) - 3'(w_pop);
    assign w_issue       = (r_count != '0) && (w_credit < 3'd2);
    assign q_if.dc_en    = w_issue;
    assign q_if.dc_wen   = w_issue && r_st[r_rp];
    assign q_if.dc_addr  = r_addr[r_rp];
    assign q_if.dc_wdata = r_wd[r_rp];
    assign q_if.dc_tag   = r_tag[r_rp];
    assign q_if.out_valid = r_rq_count != 2'd0;
    assign q_if.out_tag   = r_rq_tag[r_rq_rp];
    assign q_if.out_data  = r_rq_data[r_rq_rp];
    assign q_if.out_store = r_rq_st[r_rq_rp];
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_st[r_wp]   <= q_if.in_store;
            r_addr[r_wp] <= q_if.in_addr;
            r_wd[r_wp]   <= q_if.in_wdata;
            r_tag[r_wp]  <= q_if.in_tag;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp       <= '0;
            r_rp       <= '0;
            r_count    <= '0;
            r_inflight <= 1'b0;
            r_if_store <= 1'b0;
            r_if_tag   <= '0;
        end else begin
            r_wp       <= w_push ? r_wp + AW'(1) : r_wp;
            r_rp       <= w_issue ? r_rp + AW'(1) : r_rp;
            r_count    <= r_count + (AW+1)'(w_push) - (AW+1)'(w_issue);
            r_inflight <= w_issue;
            r_if_store <= w_issue ? r_st[r_rp] : r_if_store;
            r_if_tag   <= w_issue ? r_tag[r_rp] : r_if_tag;
        end
    end
    // Result entries are reset so the idle result port reads all-zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rq_st    <= '{default: '0};
            r_rq_tag   <= '{default: '0};
            r_rq_data  <= '{default: '0};
            r_rq_wp    <= 1'b0;
            r_rq_rp    <= 1'b0;
            r_rq_count <= '0;
        end else begin
            if (r_inflight) begin
                r_rq_st[r_rq_wp]   <= r_if_store;
                r_rq_tag[r_rq_wp]  <= r_if_tag;
                r_rq_data[r_rq_wp] <= r_if_store ? 32'h0 : q_if.dc_rdata;
            end
            r_rq_wp    <= r_inflight ? ~r_rq_wp : r_rq_wp;
            r_rq_rp    <= w_pop ? ~r_rq_rp : r_rq_rp;
            r_rq_count <= r_rq_count + 2'(r_inflight) - 2'(w_pop);
        end
    end
endmodule

// File: tb/tb_ls_issue_queue.sv
// tb_ls_issue_queue: directed and random stimulus against an occupancy-counting reference model with a dcache model.
module tb_ls_issue_queue;
    localparam int DEPTH = 4;
    typedef struct {
        logic        st;
        logic [15:0] a;
        logic [31:0] d;
        logic [5:0]  t;
    } op_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    op_t  iss_q[$];
    op_t  cmp_q[$];
    int   n_out = 0;
    bit   last_iss = 1'b0;
    logic [31:0] dc_mem  [65536];
    logic [31:0] mdl_mem [65536];
    always #5 clk = ~clk;
    ls_issue_queue_if q_if ();
    ls_issue_queue #(.DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .q_if(q_if));
    // Single-port dcache: read data appears the cycle after the request
    always @(posedge clk) begin
        if (q_if.dc_en) begin
            if (q_if.dc_wen) dc_mem[q_if.dc_addr] <= q_if.dc_wdata;
            q_if.dc_rdata <= dc_mem[q_if.dc_addr];
        end
    end
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic step(input bit v, input bit st, input logic [15:0] a, input logic [31:0] d,
                        input logic [5:0] t, input bit rdy);
        bit  er, ei, ev, pop;
        op_t o;
        q_if.in_valid  = v;
        q_if.in_store  = st;
        q_if.in_addr   = a;
        q_if.in_wdata  = d;
        q_if.in_tag    = t;
        q_if.out_ready = rdy;
        @(negedge clk);
        er  = iss_q.size() < DEPTH;
        ev  = (n_out - int'(last_iss)) > 0;
        pop = ev && rdy;
        ei  = (iss_q.size() > 0) && ((n_out - int'(pop)) < 2);
        chk("in_ready", 32'(q_if.in_ready), 32'(er));
        chk("dc_en", 32'(q_if.dc_en), 32'(ei));
        chk("out_valid", 32'(q_if.out_valid), 32'(ev));
        chk("dc_wen", 32'(q_if.dc_wen), ei ? 32'(iss_q[0].st) : 32'd0);
        if (ei) begin
            chk("dc_addr", 32'(q_if.dc_addr), 32'(iss_q[0].a));
            chk("dc_tag", 32'(q_if.dc_tag), 32'(iss_q[0].t));
            if (iss_q[0].st) chk("dc_wdata", q_if.dc_wdata, iss_q[0].d);
        end
        if (ev) begin
            chk("out_tag", 32'(q_if.out_tag), 32'(cmp_q[0].t));
            chk("out_data", q_if.out_data, cmp_q[0].d);
            chk("out_store", 32'(q_if.out_store), 32'(cmp_q[0].st));
        end
        if (ei) begin
            void'(iss_q.pop_front());
            n_out++;
        end
        if (pop) begin
            void'(cmp_q.pop_front());
            n_out--;
        end
        last_iss = ei;
        if (v && er) begin
            o = '{st, a, d, t};
            iss_q.push_back(o);
            o.d = st ? 32'h0 : mdl_mem[a];
            if (st) mdl_mem[a] = d;
            cmp_q.push_back(o);
        end
        @(posedge clk);
        #1;
    endtask
    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, 32'h0, 6'h0, rdy);
    endtask
    task automatic rst_chk(input string p);
        chk({p, "_in_ready"}, 32'(q_if.in_ready), 32'd1);
        chk({p, "_dc_en"}, 32'(q_if.dc_en), 32'd0);
        chk({p, "_dc_wen"}, 32'(q_if.dc_wen), 32'd0);
        chk({p, "_out_valid"}, 32'(q_if.out_valid), 32'd0);
        chk({p, "_out_tag"}, 32'(q_if.out_tag), 32'd0);
        chk({p, "_out_data"}, q_if.out_data, 32'd0);
        chk({p, "_out_store"}, 32'(q_if.out_store), 32'd0);
    endtask
    initial begin
        for (int i = 0; i < 65536; i++) begin
            dc_mem[i]  = i * 32'h9E3779B1;
            mdl_mem[i] = dc_mem[i];
        end
        dc_mem[16]  = 32'hDEADBEEF;
        mdl_mem[16] = 32'hDEADBEEF;
        q_if.in_valid  = 1'b0;
        q_if.in_store  = 1'b0;
        q_if.in_addr   = '0;
        q_if.in_wdata  = '0;
        q_if.in_tag    = '0;
        q_if.out_ready = 1'b0;
        #1;
        rst_chk("por");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        // single load, then store followed by a load of the same word
        step(1'b1, 1'b0, 16'h0010, 32'h0, 6'd5, 1'b1);
        idle(4, 1'b1);
        step(1'b1, 1'b1, 16'h0020, 32'h12345678, 6'd1, 1'b1);
        step(1'b1, 1'b0, 16'h0020, 32'h0, 6'd2, 1'b1);
        idle(5, 1'b1);
        // fill with the result port stalled, then drain
        for (int i = 0; i < 7; i++) step(1'b1, i[0], 16'h0030 + 16'(i), 32'hA000 + i, 6'(10 + i), 1'b0);
        idle(10, 1'b1);
        // enqueue, issue and pop together with the request queue one short of full
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 16'h0040 + 16'(i), 32'h0, 6'(20 + i), 1'b0);
        idle(2, 1'b0);
        step(1'b1, 1'b1, 16'h0050, 32'hCAFE0001, 6'd30, 1'b1);
        idle(8, 1'b1);
        // alternating stall over eight loads
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 16'h0060 + 16'(i), 32'h0, 6'(40 + i), i[0]);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 16'h0, 32'h0, 6'h0, i[0]);
        // reset with three queued and one in flight
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 16'h0070 + 16'(i), 32'hB000 + i, 6'(50 + i), 1'b0);
        idle(2, 1'b0);
        step(1'b1, 1'b0, 16'h0078, 32'h0, 6'd58, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        rst_chk("mid");
        iss_q.delete();
        cmp_q.delete();
        n_out    = 0;
        last_iss = 1'b0;
        q_if.in_valid  = 1'b0;
        q_if.out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 65536; i++) mdl_mem[i] = dc_mem[i];
        @(posedge clk);
        #1;
        step(1'b1, 1'b0, 16'h0010, 32'h0, 6'd9, 1'b1);
        idle(5, 1'b1);
        // random traffic over a small address window to exercise store/load ordering
        for (int i = 0; i < 1500; i++)
            step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 4, 16'h0080 + 16'($urandom_range(0, 15)),
                 $urandom, 6'($urandom), $urandom_range(0, 9) < 6);
        idle(20, 1'b1);
        chk("drained", 32'(iss_q.size() + cmp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
